inst_mem_arbiter: RTL and testbench

- Owns the single-port instruction SRAM and shares it between the fetch stage and the program loader/debug port.
- Sequences each SRAM access with a configurable wait-state count and returns fetched words with a one-cycle ack.
- Drives the fetch-stage clock enable so the PC advances only when an instruction has actually been delivered.
- Sits between the fetch stage, the loader and the external SRAM pins.

---
 rtl/inst_mem_arbiter_pkg.sv | 41 ++++
 rtl/imem_wait_counter.sv | 30 +++
 rtl/inst_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_inst_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: FSM state encodings,
// grant identifiers, the legal wait-state range and the arbitration helper.
package inst_mem_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_e;

   localparam logic GNT_FETCH = 1'b0;
   localparam logic GNT_LDR   = 1'b1;

   localparam int MEM_WAIT_MIN = 1;
   localparam int MEM_WAIT_MAX = 7;

   // Keep the wait-state count inside what the 3-bit wait counter can express.
   function automatic int clamp_wait(input int w);
      if (w < MEM_WAIT_MIN) begin
         return MEM_WAIT_MIN;
      end else if (w > MEM_WAIT_MAX) begin
         return MEM_WAIT_MAX;
      end else begin
         return w;
      end
   endfunction

   // A lone requester wins; when both request, the one not served last wins.
   function automatic logic arb_pick(input logic fetch_req,
                                     input logic ldr_req,
                                     input logic last_grant);
      if (fetch_req && ldr_req) begin
         return ~last_grant;
      end else if (ldr_req) begin
         return GNT_LDR;
      end else begin
         return GNT_FETCH;
      end
   endfunction

endpackage

// File: rtl/imem_wait_counter.sv
// Loadable 3-bit down counter with a zero flag; paces chip-select wait states.
module imem_wait_counter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [2:0] load_val,
   input  logic       dec,
   output logic [2:0] count,
   output logic       zero
);

   logic [2:0] count_r;

   // Load takes priority; decrement stops at zero so the count never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= 3'd0;
      end else if (load) begin
         count_r <= load_val;
      end else if (dec && (count_r != 3'd0)) begin
         count_r <= count_r - 3'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;
   assign zero  = (count_r == 3'd0);

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares the single-port instruction SRAM between the fetch stage and the
// loader/debug port, sequences wait states and gates the PC clock enable.
module inst_mem_arbiter
   import inst_mem_arbiter_pkg::*;
#(
   parameter int INST_DATA_WIDTH = 32,
   parameter int INST_ADDR_WIDTH = 20,
   parameter int MEM_WAIT_CYCLES = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fetch_req_in,
   input  logic [INST_ADDR_WIDTH-1:0] fetch_addr_in,
   output logic                       fetch_ack_out,
   output logic [INST_DATA_WIDTH-1:0] fetch_data_out,
   output logic                       fetch_clk_en_out,
   input  logic                       hold_in,
   input  logic                       ldr_req_in,
   input  logic                       ldr_we_in,
   input  logic [INST_ADDR_WIDTH-1:0] ldr_addr_in,
   input  logic [INST_DATA_WIDTH-1:0] ldr_wdata_in,
   output logic                       ldr_ack_out,
   output logic [INST_DATA_WIDTH-1:0] ldr_rdata_out,
   output logic                       mem_cs_n_out,
   output logic                       mem_we_n_out,
   output logic [INST_ADDR_WIDTH-1:0] mem_addr_out,
   output logic [INST_DATA_WIDTH-1:0] mem_wdata_out,
   input  logic [INST_DATA_WIDTH-1:0] mem_rdata_in
);

   localparam int         WAIT_EFF  = clamp_wait(MEM_WAIT_CYCLES);
   localparam logic [2:0] WAIT_LOAD = 3'(WAIT_EFF - 1);

   arb_state_e state_r;
   arb_state_e state_next_s;

   logic last_grant_r;
   logic acc_we_r;
   logic fetch_ack_r;
   logic ldr_ack_r;
   logic mem_cs_n_r;
   logic mem_we_n_r;
   logic [INST_ADDR_WIDTH-1:0] mem_addr_r;
   logic [INST_DATA_WIDTH-1:0] mem_wdata_r;
   logic [INST_DATA_WIDTH-1:0] fetch_data_r;
   logic [INST_DATA_WIDTH-1:0] ldr_rdata_r;

   logic       req_any_s;
   logic       grant_s;
   logic       start_we_s;
   logic       resp_hold_s;
   logic       start_s;
   logic       acc_active_s;
   logic       cnt_dec_s;
   logic       cnt_zero_s;
   logic [2:0] cnt_s;
   logic       cs_n_next_s;
   logic       we_n_next_s;
   logic       fetch_ack_next_s;
   logic       ldr_ack_next_s;
   logic       cap_fetch_s;
   logic       cap_ldr_s;

   assign req_any_s   = fetch_req_in | ldr_req_in;
   assign grant_s     = arb_pick(fetch_req_in, ldr_req_in, last_grant_r);
   assign start_we_s  = (grant_s == GNT_LDR) & ldr_we_in;
   assign resp_hold_s = (last_grant_r == GNT_FETCH) & hold_in;

   imem_wait_counter u_wait_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_s),
      .load_val (WAIT_LOAD),
      .dec      (cnt_dec_s),
      .count    (cnt_s),
      .zero     (cnt_zero_s)
   );

   // State register; reset abandons any in-flight access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state: RESP chains straight into a new ACCESS when work is pending.
   always_comb begin
      state_next_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (req_any_s) begin
               state_next_s = ST_ACCESS;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            if (cnt_zero_s) begin
               state_next_s = ST_RESP;
            end else begin
               state_next_s = ST_ACCESS;
            end
         end
         ST_RESP: begin
            if (resp_hold_s) begin
               state_next_s = ST_RESP;
            end else if (req_any_s) begin
               state_next_s = ST_ACCESS;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Output decode: next values for the registered strobes and capture enables.
   always_comb begin
      start_s          = 1'b0;
      acc_active_s     = 1'b0;
      cnt_dec_s        = 1'b0;
      fetch_ack_next_s = 1'b0;
      ldr_ack_next_s   = 1'b0;
      cap_fetch_s      = 1'b0;
      cap_ldr_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            start_s = req_any_s;
         end
         ST_ACCESS: begin
            cnt_dec_s = 1'b1;
            if (cnt_zero_s) begin
               fetch_ack_next_s = (last_grant_r == GNT_FETCH);
               ldr_ack_next_s   = (last_grant_r == GNT_LDR);
               cap_fetch_s      = (last_grant_r == GNT_FETCH);
               cap_ldr_s        = (last_grant_r == GNT_LDR) & ~acc_we_r;
            end else begin
               acc_active_s = 1'b1;
            end
         end
         ST_RESP: begin
            if (resp_hold_s) begin
               fetch_ack_next_s = 1'b1;
            end else begin
               start_s = req_any_s;
            end
         end
         default: begin
            start_s = 1'b0;
         end
      endcase
      cs_n_next_s = ~(start_s | acc_active_s);
      we_n_next_s = start_s ? ~start_we_s : ~(acc_active_s & acc_we_r);
   end

   // Registered outputs, grant bookkeeping and read-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_r <= GNT_LDR;
         acc_we_r     <= 1'b0;
         fetch_ack_r  <= 1'b0;
         ldr_ack_r    <= 1'b0;
         mem_cs_n_r   <= 1'b1;
         mem_we_n_r   <= 1'b1;
         mem_addr_r   <= '0;
         mem_wdata_r  <= '0;
         fetch_data_r <= '0;
         ldr_rdata_r  <= '0;
      end else begin
         mem_cs_n_r  <= cs_n_next_s;
         mem_we_n_r  <= we_n_next_s;
         fetch_ack_r <= fetch_ack_next_s;
         ldr_ack_r   <= ldr_ack_next_s;
         if (start_s) begin
            last_grant_r <= grant_s;
            acc_we_r     <= start_we_s;
            mem_addr_r   <= (grant_s == GNT_LDR) ? ldr_addr_in : fetch_addr_in;
            if (grant_s == GNT_LDR) begin
               mem_wdata_r <= ldr_wdata_in;
            end
         end
         if (cap_fetch_s) begin
            fetch_data_r <= mem_rdata_in;
         end
         if (cap_ldr_s) begin
            ldr_rdata_r <= mem_rdata_in;
         end
      end
   end

   assign fetch_ack_out    = fetch_ack_r;
   assign fetch_data_out   = fetch_data_r;
   assign fetch_clk_en_out = fetch_ack_r & ~hold_in;
   assign ldr_ack_out      = ldr_ack_r;
   assign ldr_rdata_out    = ldr_rdata_r;
   assign mem_cs_n_out     = mem_cs_n_r;
   assign mem_we_n_out     = mem_we_n_r;
   assign mem_addr_out     = mem_addr_r;
   assign mem_wdata_out    = mem_wdata_r;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Scoreboard bench for inst_mem_arbiter: instance A (1 wait state) carries the
// fetch/loader scenarios, instance B (3 wait states) the long-access fetches.
module tb_inst_mem_arbiter;

   localparam int AW = 20;
   localparam int DW = 32;

   typedef struct packed {
      logic          is_ldr;
      logic          chk;
      logic [DW-1:0] data;
   } exp_t;

   logic clk;
   logic rst_n;

   logic          a_fetch_req, a_fetch_ack, a_fetch_clk_en, a_hold;
   logic [AW-1:0] a_fetch_addr, a_ldr_addr, a_mem_addr;
   logic [DW-1:0] a_fetch_data, a_ldr_wdata, a_ldr_rdata, a_mem_wdata, a_mem_rdata;
   logic          a_ldr_req, a_ldr_we, a_ldr_ack, a_cs_n, a_we_n;

   logic          b_fetch_req, b_fetch_ack, b_fetch_clk_en, b_hold;
   logic [AW-1:0] b_fetch_addr, b_ldr_addr, b_mem_addr;
   logic [DW-1:0] b_fetch_data, b_ldr_wdata, b_ldr_rdata, b_mem_wdata, b_mem_rdata;
   logic          b_ldr_req, b_ldr_we, b_ldr_ack, b_cs_n, b_we_n;

   logic [DW-1:0] sram_a [64];
   logic [63:0]   sram_a_vld;

   exp_t sb_a[$];
   exp_t sb_b[$];
   exp_t mon_a_e;
   exp_t mon_b_e;

   int n_cmp = 0;
   int n_err = 0;

   inst_mem_arbiter #(.INST_DATA_WIDTH(DW), .INST_ADDR_WIDTH(AW), .MEM_WAIT_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .fetch_req_in(a_fetch_req), .fetch_addr_in(a_fetch_addr), .fetch_ack_out(a_fetch_ack),
      .fetch_data_out(a_fetch_data), .fetch_clk_en_out(a_fetch_clk_en), .hold_in(a_hold),
      .ldr_req_in(a_ldr_req), .ldr_we_in(a_ldr_we), .ldr_addr_in(a_ldr_addr),
      .ldr_wdata_in(a_ldr_wdata), .ldr_ack_out(a_ldr_ack), .ldr_rdata_out(a_ldr_rdata),
      .mem_cs_n_out(a_cs_n), .mem_we_n_out(a_we_n), .mem_addr_out(a_mem_addr),
      .mem_wdata_out(a_mem_wdata), .mem_rdata_in(a_mem_rdata)
   );

   inst_mem_arbiter #(.INST_DATA_WIDTH(DW), .INST_ADDR_WIDTH(AW), .MEM_WAIT_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .fetch_req_in(b_fetch_req), .fetch_addr_in(b_fetch_addr), .fetch_ack_out(b_fetch_ack),
      .fetch_data_out(b_fetch_data), .fetch_clk_en_out(b_fetch_clk_en), .hold_in(b_hold),
      .ldr_req_in(b_ldr_req), .ldr_we_in(b_ldr_we), .ldr_addr_in(b_ldr_addr),
      .ldr_wdata_in(b_ldr_wdata), .ldr_ack_out(b_ldr_ack), .ldr_rdata_out(b_ldr_rdata),
      .mem_cs_n_out(b_cs_n), .mem_we_n_out(b_we_n), .mem_addr_out(b_mem_addr),
      .mem_wdata_out(b_mem_wdata), .mem_rdata_in(b_mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Power-on contents of the SRAM model for words never written.
   function automatic logic [DW-1:0] init_word(input logic [5:0] idx);
      case (idx)
         6'd1:    return 32'h2001_0005;
         6'd2:    return 32'h0BAD_F00D;
         default: return 32'h1000_0000 | {26'd0, idx};
      endcase
   endfunction

   function automatic exp_t mk(input logic is_ldr, input logic chk, input logic [DW-1:0] d);
      exp_t e;
      e.is_ldr = is_ldr;
      e.chk    = chk;
      e.data   = d;
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // SRAM model for instance A: asynchronous read, write on a clock edge with cs_n/we_n low.
   always @(posedge clk) begin
      if (!rst_n) begin
         sram_a_vld <= '0;
      end else if (!a_cs_n && !a_we_n) begin
         sram_a[a_mem_addr[7:2]]     <= a_mem_wdata;
         sram_a_vld[a_mem_addr[7:2]] <= 1'b1;
      end
   end
   assign a_mem_rdata = sram_a_vld[a_mem_addr[7:2]] ? sram_a[a_mem_addr[7:2]] : init_word(a_mem_addr[7:2]);
   assign b_mem_rdata = init_word(b_mem_addr[7:2]);

   // Scoreboard A: each PC enable or loader ack retires the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && a_fetch_clk_en) begin
         if (sb_a.size() == 0) begin
            check("a_fetch_unexpected", 32'd1, 32'd0);
         end else begin
            mon_a_e = sb_a.pop_front();
            check("a_fetch_kind", 32'd0, {31'd0, mon_a_e.is_ldr});
            check("a_fetch_data", a_fetch_data, mon_a_e.data);
         end
      end
      if (rst_n && a_ldr_ack) begin
         if (sb_a.size() == 0) begin
            check("a_ldr_unexpected", 32'd1, 32'd0);
         end else begin
            mon_a_e = sb_a.pop_front();
            check("a_ldr_kind", 32'd1, {31'd0, mon_a_e.is_ldr});
            if (mon_a_e.chk) check("a_ldr_rdata", a_ldr_rdata, mon_a_e.data);
         end
      end
   end

   // Scoreboard B: fetch deliveries only.
   always @(negedge clk) begin
      if (rst_n && b_fetch_clk_en) begin
         if (sb_b.size() == 0) begin
            check("b_fetch_unexpected", 32'd1, 32'd0);
         end else begin
            mon_b_e = sb_b.pop_front();
            check("b_fetch_data", b_fetch_data, mon_b_e.data);
         end
      end
   end

   task automatic a_fetch(input logic [AW-1:0] addr, input logic [DW-1:0] exp_d, input string tag);
      int cyc = 0, cs_low = 0, ack_cyc = -1;
      a_fetch_addr = addr;
      a_fetch_req  = 1'b1;
      sb_a.push_back(mk(1'b0, 1'b1, exp_d));
      while (ack_cyc < 0 && cyc < 20) begin
         @(posedge clk); #1; cyc++;
         if (!a_cs_n) cs_low++;
         if (a_fetch_ack) ack_cyc = cyc;
      end
      a_fetch_req = 1'b0;
      check({tag, "_latency"}, ack_cyc, 32'd2);
      check({tag, "_cs_cycles"}, cs_low, 32'd1);
      check({tag, "_clk_en"}, {31'd0, a_fetch_clk_en}, 32'd1);
      @(posedge clk); #1;
      check({tag, "_ack_pulse"}, {31'd0, a_fetch_ack}, 32'd0);
   endtask

   task automatic a_ldr(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] exp_d, input string tag);
      int cyc = 0, cs_low = 0, we_low = 0, ack_cyc = -1;
      a_ldr_we    = we;
      a_ldr_addr  = addr;
      a_ldr_wdata = wd;
      a_ldr_req   = 1'b1;
      sb_a.push_back(mk(1'b1, ~we, exp_d));
      while (ack_cyc < 0 && cyc < 20) begin
         @(posedge clk); #1; cyc++;
         if (!a_cs_n) cs_low++;
         if (!a_we_n) we_low++;
         if (a_ldr_ack) ack_cyc = cyc;
      end
      a_ldr_req = 1'b0;
      check({tag, "_latency"}, ack_cyc, 32'd2);
      check({tag, "_cs_cycles"}, cs_low, 32'd1);
      check({tag, "_we_cycles"}, we_low, we ? 32'd1 : 32'd0);
      @(posedge clk); #1;
      check({tag, "_ack_pulse"}, {31'd0, a_ldr_ack}, 32'd0);
   endtask

   task automatic b_fetch(input logic [AW-1:0] addr, input logic [DW-1:0] exp_d,
                          input logic early_drop, input string tag);
      int cyc = 0, cs_low = 0, we_low = 0, ack_cyc = -1;
      b_fetch_addr = addr;
      b_fetch_req  = 1'b1;
      sb_b.push_back(mk(1'b0, 1'b1, exp_d));
      while (ack_cyc < 0 && cyc < 30) begin
         @(posedge clk); #1; cyc++;
         if (!b_cs_n) cs_low++;
         if (!b_we_n) we_low++;
         if (b_fetch_ack) ack_cyc = cyc;
         if (early_drop && cyc == 1) b_fetch_req = 1'b0;
      end
      b_fetch_req = 1'b0;
      check({tag, "_latency"}, ack_cyc, 32'd4);
      check({tag, "_cs_cycles"}, cs_low, 32'd3);
      check({tag, "_we_cycles"}, we_low, 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, n_ack, prev, ack_cyc, ack_hi, en_hi, en_lo_ack, unstable, acks, cs_low;
      rst_n = 1'b1;
      a_fetch_req = 1'b0; a_fetch_addr = '0; a_hold = 1'b0;
      a_ldr_req = 1'b0; a_ldr_we = 1'b0; a_ldr_addr = '0; a_ldr_wdata = '0;
      b_fetch_req = 1'b0; b_fetch_addr = '0; b_hold = 1'b0;
      b_ldr_req = 1'b0; b_ldr_we = 1'b0; b_ldr_addr = '0; b_ldr_wdata = '0;

      // Reset values.
      #2 rst_n = 1'b0;
      #1;
      check("rst_cs_n", {31'd0, a_cs_n}, 32'd1);
      check("rst_we_n", {31'd0, a_we_n}, 32'd1);
      check("rst_acks", {30'd0, a_fetch_ack, a_ldr_ack}, 32'd0);
      check("rst_clk_en", {31'd0, a_fetch_clk_en}, 32'd0);
      check("rst_fetch_data", a_fetch_data, 32'd0);
      check("rst_ldr_rdata", a_ldr_rdata, 32'd0);
      check("rst_mem_addr", {12'd0, a_mem_addr}, 32'd0);
      check("rst_mem_wdata", a_mem_wdata, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Contention: alternating grants starting with fetch, one ack every 2 cycles.
      a_fetch_addr = 20'h00004; a_ldr_addr = 20'h00008; a_ldr_we = 1'b0;
      a_fetch_req = 1'b1; a_ldr_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sb_a.push_back(mk(1'b0, 1'b1, 32'h2001_0005));
         sb_a.push_back(mk(1'b1, 1'b1, 32'h0BAD_F00D));
      end
      cyc = 0; n_ack = 0; prev = 0;
      while (n_ack < 6 && cyc < 40) begin
         @(posedge clk); #1; cyc++;
         if (a_fetch_ack || a_ldr_ack) begin
            n_ack++;
            check("cont_grant_order", {31'd0, a_ldr_ack}, (n_ack % 2 == 0) ? 32'd1 : 32'd0);
            if (n_ack > 1) check("cont_spacing", cyc - prev, 32'd2);
            prev = cyc;
         end
      end
      a_fetch_req = 1'b0; a_ldr_req = 1'b0;
      check("cont_ack_count", n_ack, 32'd6);
      @(posedge clk); #1;

      // Single fetches and loader traffic.
      a_fetch(20'h00004, 32'h2001_0005, "fetch_single");
      a_ldr(1'b1, 20'h00010, 32'hDEAD_BEEF, 32'd0, "ldr_write");
      check("ldr_write_keeps_rdata", a_ldr_rdata, 32'h0BAD_F00D);
      a_fetch(20'h00010, 32'hDEAD_BEEF, "fetch_after_write");
      a_ldr(1'b0, 20'h00014, 32'd0, init_word(6'd5), "ldr_read");

      // Stall: hold from the fetch RESP cycle for 3 cycles.
      a_fetch_addr = 20'h0000C; a_fetch_req = 1'b1;
      sb_a.push_back(mk(1'b0, 1'b1, init_word(6'd3)));
      cyc = 0; ack_cyc = -1;
      while (ack_cyc < 0 && cyc < 20) begin
         @(posedge clk); #1; cyc++;
         if (a_fetch_ack) ack_cyc = cyc;
      end
      check("stall_latency", ack_cyc, 32'd2);
      a_hold = 1'b1; a_fetch_req = 1'b0;
      ack_hi = 0; en_hi = 0; en_lo_ack = 0; unstable = 0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) begin
            @(posedge clk); #1;
            if (k == 3) a_hold = 1'b0;
         end
         #1;
         if (a_fetch_ack) ack_hi++;
         if (a_fetch_clk_en) en_hi++;
         if (a_fetch_ack && !a_fetch_clk_en) en_lo_ack++;
         if (a_fetch_ack && a_fetch_data !== init_word(6'd3)) unstable++;
      end
      check("stall_ack_cycles", ack_hi, 32'd4);
      check("stall_clk_en_high", en_hi, 32'd1);
      check("stall_clk_en_low", en_lo_ack, 32'd3);
      check("stall_data_stable", unstable, 32'd0);

      // Reset in the middle of a loader write: strobes drop at once, no ack afterwards.
      @(posedge clk); #1;
      a_ldr_we = 1'b1; a_ldr_addr = 20'h00020; a_ldr_wdata = 32'h1111_1111; a_ldr_req = 1'b1;
      @(posedge clk); #1;
      check("mid_access_cs_low", {31'd0, a_cs_n}, 32'd0);
      check("mid_access_we_low", {31'd0, a_we_n}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("async_rst_cs_n", {31'd0, a_cs_n}, 32'd1);
      check("async_rst_we_n", {31'd0, a_we_n}, 32'd1);
      check("async_rst_acks", {29'd0, a_fetch_ack, a_ldr_ack, a_fetch_clk_en}, 32'd0);
      a_ldr_req = 1'b0; a_ldr_we = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      acks = 0; cs_low = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (a_fetch_ack || a_ldr_ack) acks++;
         if (!a_cs_n) cs_low++;
      end
      check("no_ack_after_rst", acks, 32'd0);
      check("idle_after_rst", cs_low, 32'd0);
      a_fetch(20'h00020, init_word(6'd8), "fetch_after_rst");

      // Three wait states, with and without an early request drop.
      b_fetch(20'h00004, 32'h2001_0005, 1'b0, "w3_fetch");
      b_fetch(20'h00008, 32'h0BAD_F00D, 1'b1, "w3_early_drop");

      repeat (3) @(posedge clk);
      #1;
      check("sb_a_drained", sb_a.size(), 32'd0);
      check("sb_b_drained", sb_b.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
